// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Saturation-limit helpers let the top stay width-generic.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_W = 8;

  // Largest positive quotient magnitude for a w-bit signed result
  function automatic int unsigned sat_pos_mag(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  // Largest negative quotient magnitude for a w-bit signed result
  function automatic int unsigned sat_neg_mag(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor
// magnitude, keep the difference only when it is non-negative.
module div_restoring_step #(
  parameter int W = 8
) (
  input  logic [W:0]   prem,
  input  logic         dbit,
  input  logic [W-1:0] dsr,
  output logic [W:0]   prem_nx,
  output logic         qbit
);

  logic [W+1:0] shifted;

  always_comb begin
    shifted = {prem, dbit};
    qbit    = (shifted >= {2'b00, dsr});
    prem_nx = qbit ? (W+1)'(shifted - {2'b00, dsr}) : shifted[W:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_DIV0_FAST_EN: a zero divisor skips the iterations and finishes at accept.
module seq_signed_divider
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [2*W-1:0] dividend,
  input  logic signed [W-1:0]   divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   quotient,
  output logic signed [W-1:0]   remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int              CW       = $clog2(2*W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(2*W - 1);
  localparam logic [2*W-1:0]  POS_MAG  = (2*W)'(sat_pos_mag(W));
  localparam logic [2*W-1:0]  NEG_MAG  = (2*W)'(sat_neg_mag(W));

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  dvd_sh;
  logic [2*W-2:0]  quo_sh;
  logic [W:0]      prem;
  logic [W-1:0]    dsr_mag;
  logic [W-1:0]    dvd_lo;
  logic            sgn_n, sgn_d, dz;

  logic [W:0]      prem_nx;
  logic            qbit;
  logic [2*W-1:0]  q_fin;
  logic [W-1:0]    r_fin;
  logic [W:0]      sat_res;
  logic [W-1:0]    rem_res;
  logic            accept;

  function automatic logic [W-1:0] negate(input logic [W-1:0] x);
    return (~x) + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] abs_dvd(input logic [2*W-1:0] x);
    return x[2*W-1] ? (~x) + {{(2*W-1){1'b0}}, 1'b1} : x;
  endfunction

  function automatic logic [W-1:0] abs_dsr(input logic [W-1:0] x);
    return x[W-1] ? negate(x) : x;
  endfunction

  // Returns {overflow, quotient}; the magnitude is clamped to the signed W-bit range
  function automatic logic [W:0] saturate(input logic [2*W-1:0] mag, input logic neg);
    if (neg) begin
      if (mag > NEG_MAG) return {1'b1, NEG_MAG[W-1:0]};
      return {1'b0, negate(mag[W-1:0])};
    end
    if (mag > POS_MAG) return {1'b1, POS_MAG[W-1:0]};
    return {1'b0, mag[W-1:0]};
  endfunction

  div_restoring_step #(.W(W)) u_step (
    .prem    (prem),
    .dbit    (dvd_sh[2*W-1]),
    .dsr     (dsr_mag),
    .prem_nx (prem_nx),
    .qbit    (qbit)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign q_fin   = {quo_sh, qbit};
  assign r_fin   = prem_nx[W-1:0];
  assign sat_res = saturate(q_fin, sgn_n ^ sgn_d);
  assign rem_res = sgn_n ? negate(r_fin) : r_fin;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef SEQ_DIVIDER_DIV0_FAST_EN
          state_nx = (divisor == '0) ? DONE : CALC;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC:    if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and presented results: reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= CNT_LAST;
`ifdef SEQ_DIVIDER_DIV0_FAST_EN
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[W-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            if (dz) begin
              quotient    <= '1;
              remainder   <= dvd_lo;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else begin
              quotient    <= sat_res[W-1:0];
              remainder   <= rem_res;
              div_by_zero <= 1'b0;
              overflow    <= sat_res[W];
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand magnitudes, signs and the shifting quotient/remainder datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_sh  <= abs_dvd(dividend);
      dsr_mag <= abs_dsr(divisor);
      sgn_n   <= dividend[2*W-1];
      sgn_d   <= divisor[W-1];
      dvd_lo  <= dividend[W-1:0];
      dz      <= (divisor == '0);
      prem    <= '0;
      quo_sh  <= '0;
    end else if (state == CALC) begin
      dvd_sh <= {dvd_sh[2*W-2:0], 1'b0};
      prem   <= prem_nx;
      quo_sh <= q_fin[2*W-2:0];
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (W=8): directed, random, handshake and reset scenarios
// compared against an integer-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int W        = 8;
  localparam int CALC_LAT = 2*W;
`ifdef SEQ_DIVIDER_DIV0_FAST_EN
  localparam int DZ_LAT   = 0;   // the accepting edge itself moves the block to DONE
`else
  localparam int DZ_LAT   = 2*W;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [2*W-1:0] dividend = '0;
  logic signed [W-1:0]   divisor = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic signed [W-1:0]   quotient;
  logic signed [W-1:0]   remainder;
  logic                  div_by_zero;
  logic                  overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign
  task automatic model(input int a, input int b, output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ovf);
    int qt, rt;
    if (b == 0) begin
      dz = 1'b1; ovf = 1'b0; q = 8'hFF; r = a[7:0];
    end else begin
      qt  = a / b;
      rt  = a % b;
      dz  = 1'b0;
      ovf = (qt > 127) || (qt < -128);
      if (qt > 127)       q = 8'h7F;
      else if (qt < -128) q = 8'h80;
      else                q = qt[7:0];
      r = rt[7:0];
    end
  endtask

  // Presents one operation (block assumed idle) and waits, bounded, for out_valid
  task automatic run_div(input int a, input int b, output int lat);
    dividend = 16'(a);
    divisor  = 8'(b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL reset quotient got %h want 00", quotient); end
    checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL reset remainder got %h want 00", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero got %b want 0", div_by_zero); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b want 0", overflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int da[12] = '{100, -100, 100, 1000, -1000, 16384, -16384, -32768, 32767, 4660, -5, 0};
    int db[12] = '{7, 7, -7, 3, 3, -128, -128, -128, 127, 0, 7, 5};
    logic [7:0] eq, er;
    logic edz, eovf;
    int lat, elat;
    for (int i = 0; i < 12; i++) begin
      model(da[i], db[i], eq, er, edz, eovf);
      elat = (db[i] == 0) ? DZ_LAT : CALC_LAT;
      run_div(da[i], db[i], lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, elat); end
      checks++; if (quotient !== eq) begin errors++; $display("FAIL directed[%0d] quotient got %h want %h", i, quotient, eq); end
      checks++; if (remainder !== er) begin errors++; $display("FAIL directed[%0d] remainder got %h want %h", i, remainder, er); end
      checks++; if (div_by_zero !== edz) begin errors++; $display("FAIL directed[%0d] div_by_zero got %b want %b", i, div_by_zero, edz); end
      checks++; if (overflow !== eovf) begin errors++; $display("FAIL directed[%0d] overflow got %b want %b", i, overflow, eovf); end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] after-release valid/ready/dz/ovf got %b%b%b%b want 0100",
                 i, out_valid, in_ready, div_by_zero, overflow);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] eq, er;
    logic edz, eovf;
    logic signed [15:0] a;
    logic signed [7:0] b, x;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      x = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a = {{8{x[7]}}, x};
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      model(int'(a), int'(b), eq, er, edz, eovf);
      run_div(int'(a), int'(b), lat);
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || overflow !== eovf) begin
        errors++;
        $display("FAIL random[%0d] %0d/%0d q,r,dz,ovf got %h,%h,%b,%b want %h,%h,%b,%b",
                 i, a, b, quotient, remainder, div_by_zero, overflow, eq, er, edz, eovf);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    logic [7:0] eq, er, eq2, er2;
    logic edz, eovf;
    int lat;
    model(-1000, 7, eq, er, edz, eovf);
    run_div(-1000, 7, lat);
    for (int i = 0; i < 5; i++) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom_range(1, 100));
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq || remainder !== er || overflow !== eovf) begin
        errors++;
        $display("FAIL hold[%0d] valid,ready,q,r,ovf got %b,%b,%h,%h,%b want 1,0,%h,%h,%b",
                 i, out_valid, in_ready, quotient, remainder, overflow, eq, er, eovf);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold release in_ready got %b want 1", in_ready); end
    model(50, -5, eq2, er2, edz, eovf);
    run_div(50, -5, lat);
    checks++;
    if (lat !== CALC_LAT || quotient !== eq2 || remainder !== er2) begin
      errors++;
      $display("FAIL hold next-op lat,q,r got %0d,%h,%h want %0d,%h,%h", lat, quotient, remainder, CALC_LAT, eq2, er2);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    logic [7:0] eq, er;
    logic edz, eovf;
    int lat;
    bit stale;
    dividend = 16'(1000);
    divisor  = 8'(3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 8'h00) begin
      errors++;
      $display("FAIL midreset valid,ready,q got %b,%b,%h want 0,1,00", out_valid, in_ready, quotient);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midreset stale result got %b want 0", stale); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready got %b want 1", in_ready); end
    model(77, -5, eq, er, edz, eovf);
    run_div(77, -5, lat);
    checks++;
    if (quotient !== eq || remainder !== er || lat !== CALC_LAT) begin
      errors++;
      $display("FAIL midreset recovery q,r,lat got %h,%h,%0d want %h,%h,%0d", quotient, remainder, lat, eq, er, CALC_LAT);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] eq, er;
    logic edz, eovf;
    int rises[$];
    logic prev;
    model(-300, 9, eq, er, edz, eovf);
    dividend  = 16'(-300);
    divisor   = 8'(9);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid && !prev) begin
        rises.push_back(cyc);
        checks++;
        if (quotient !== eq || remainder !== er) begin
          errors++;
          $display("FAIL b2b q,r got %h,%h want %h,%h", quotient, remainder, eq, er);
        end
      end
      prev = out_valid;
    end
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (rises.size() < 2) begin
      errors++;
      $display("FAIL b2b results seen got %0d want >=2", rises.size());
    end else if (rises[1] - rises[0] !== 2*W + 2) begin
      errors++;
      $display("FAIL b2b spacing got %0d want %0d", rises[1] - rises[0], 2*W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
